mux_nw_reg: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.

---
 rtl/mux_nw_reg.sv | 142 ++++++++++++++
 tb/tb_mux_nw_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nw_reg.sv
// mux_nw_reg: N-channel, W-bit registered multiplexer with a valid/ready handshake.
// One output word is buffered. The channel is chosen either by an explicit select
// (MODE=0) or by a round-robin search over the valid channels (MODE=1).
// A saturating counter tracks how many input words have been accepted.
module mux_nw_reg #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*W-1:0]     in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               sel_err,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   xfer_cnt
);

  // State registers and their next-state values
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_chan_q,  out_chan_d;
  logic               sel_err_q,   sel_err_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;

  // Combinational arbitration results
  logic               load_en;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_idx;
  logic [W-1:0]       grant_data;
  logic               xfer;

  // The output register may accept a new word when it is empty or being drained.
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && grant_valid;

  // Pick the granted channel: explicit select, or first valid channel from rr_ptr onwards.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the earliest hit overrides later ones.
      for (int k = N - 1; k >= 0; k--) begin
        int j;
        j = 32'(rr_ptr_q) + k;
        if (j >= N) j = j - N;
        for (int i = 0; i < N; i++) begin
          if (i == j && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end
    end
  end

  // Route the granted channel's data towards the output register.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*W +: W];
    end
  end

  // One ready bit per channel; only the granted channel sees ready, and only when loading.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = load_en && grant_valid && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // Next-state logic for the output buffer, round-robin pointer, error pulse and counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    sel_err_d   = (MODE == 0) && load_en && (32'(sel) >= N);

    if (load_en) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_chan_d  = grant_idx;
        rr_ptr_d    = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
      end else begin
        // Nothing to load: the buffer empties but keeps its last word and channel.
        out_valid_d = 1'b0;
      end
    end

    // Clearing wins over counting; the counter sticks at all-ones.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with immediate reset that discards any buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      sel_err_q   <= 1'b0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      sel_err_q   <= sel_err_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign sel_err   = sel_err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_nw_reg.sv
// Testbench for mux_nw_reg: three instances (explicit select N=4 with a 4-bit counter,
// round-robin N=4, explicit select N=3) checked every cycle against a behavioural model,
// plus directed literal expectations for the key scenarios.
module tb_mux_nw_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, W=8, MODE=0, CNT_W=4
  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_data;
  logic [1:0]  a_sel, a_ochan;
  logic        a_ordy, a_ovalid, a_err, a_clr;
  logic [7:0]  a_odata;
  logic [3:0]  a_cnt;

  // Instance B: N=4, W=8, MODE=1, CNT_W=16
  logic [3:0]  b_valid, b_ready;
  logic [31:0] b_data;
  logic [1:0]  b_sel, b_ochan;
  logic        b_ordy, b_ovalid, b_err, b_clr;
  logic [7:0]  b_odata;
  logic [15:0] b_cnt;

  // Instance C: N=3, W=8, MODE=0, CNT_W=16
  logic [2:0]  c_valid, c_ready;
  logic [23:0] c_data;
  logic [1:0]  c_sel, c_ochan;
  logic        c_ordy, c_ovalid, c_err, c_clr;
  logic [7:0]  c_odata;
  logic [15:0] c_cnt;

  mux_nw_reg #(.N(4), .W(8), .MODE(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .sel(a_sel), .out_valid(a_ovalid), .out_ready(a_ordy), .out_data(a_odata),
    .out_chan(a_ochan), .sel_err(a_err), .clr_cnt(a_clr), .xfer_cnt(a_cnt));

  mux_nw_reg #(.N(4), .W(8), .MODE(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .sel(b_sel), .out_valid(b_ovalid), .out_ready(b_ordy), .out_data(b_odata),
    .out_chan(b_ochan), .sel_err(b_err), .clr_cnt(b_clr), .xfer_cnt(b_cnt));

  mux_nw_reg #(.N(3), .W(8), .MODE(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .sel(c_sel), .out_valid(c_ovalid), .out_ready(c_ordy), .out_data(c_odata),
    .out_chan(c_ochan), .sel_err(c_err), .clr_cnt(c_clr), .xfer_cnt(c_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    int         chan;
    logic       err;
    int         cnt;
    int         ptr;
  } st_t;

  function automatic st_t rst_st();
    st_t r;
    r.v = 1'b0; r.d = 8'h00; r.chan = 0; r.err = 1'b0; r.cnt = 0; r.ptr = 0;
    return r;
  endfunction

  // Which channel wins, or -1 for none.
  function automatic int mdl_grant(int n, int mode, int ptr, logic [3:0] vld, int sel);
    if (mode == 0) begin
      if (sel < n && vld[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mdl_ready(int n, int mode, st_t s, logic [3:0] vld,
                                           int sel, logic ordy);
    int g;
    logic [3:0] r;
    r = 4'b0000;
    if (!s.v || ordy) begin
      g = mdl_grant(n, mode, s.ptr, vld, sel);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  function automatic st_t mdl_step(int n, int mode, int cmax, st_t s, logic [3:0] vld,
                                   logic [31:0] dat, int sel, logic ordy, logic clr);
    st_t r;
    logic le;
    int g;
    r  = s;
    le = !s.v || ordy;
    g  = le ? mdl_grant(n, mode, s.ptr, vld, sel) : -1;
    r.err = (mode == 0) && le && (sel >= n);
    if (le) begin
      if (g >= 0) begin
        r.v = 1'b1; r.d = dat[g*8 +: 8]; r.chan = g; r.ptr = (g + 1) % n;
      end else begin
        r.v = 1'b0;
      end
    end
    if (clr) r.cnt = 0;
    else if (g >= 0 && s.cnt < cmax) r.cnt = s.cnt + 1;
    return r;
  endfunction

  st_t ma, mb, mc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= rst_st();
      mb <= rst_st();
      mc <= rst_st();
    end else begin
      ma <= mdl_step(4, 0, 15, ma, a_valid, a_data, int'(a_sel), a_ordy, a_clr);
      mb <= mdl_step(4, 1, 65535, mb, b_valid, b_data, int'(b_sel), b_ordy, b_clr);
      mc <= mdl_step(3, 0, 65535, mc, {1'b0, c_valid}, {8'h00, c_data}, int'(c_sel),
                     c_ordy, c_clr);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("A.out_valid", 32'(a_ovalid), 32'(ma.v));
      chk("A.out_data",  32'(a_odata),  32'(ma.d));
      chk("A.out_chan",  32'(a_ochan),  32'(ma.chan));
      chk("A.sel_err",   32'(a_err),    32'(ma.err));
      chk("A.xfer_cnt",  32'(a_cnt),    32'(ma.cnt));
      chk("A.in_ready",  32'(a_ready),  32'(mdl_ready(4, 0, ma, a_valid, int'(a_sel), a_ordy)));
      chk("B.out_valid", 32'(b_ovalid), 32'(mb.v));
      chk("B.out_data",  32'(b_odata),  32'(mb.d));
      chk("B.out_chan",  32'(b_ochan),  32'(mb.chan));
      chk("B.sel_err",   32'(b_err),    32'(mb.err));
      chk("B.xfer_cnt",  32'(b_cnt),    32'(mb.cnt));
      chk("B.in_ready",  32'(b_ready),  32'(mdl_ready(4, 1, mb, b_valid, int'(b_sel), b_ordy)));
      chk("C.out_valid", 32'(c_ovalid), 32'(mc.v));
      chk("C.out_data",  32'(c_odata),  32'(mc.d));
      chk("C.out_chan",  32'(c_ochan),  32'(mc.chan));
      chk("C.sel_err",   32'(c_err),    32'(mc.err));
      chk("C.xfer_cnt",  32'(c_cnt),    32'(mc.cnt));
      chk("C.in_ready",  32'(c_ready),
          32'(mdl_ready(3, 0, mc, {1'b0, c_valid}, int'(c_sel), c_ordy)));
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int exp_seq [8] = '{0, 1, 2, 3, 0, 3, 0, 3};

  initial begin
    a_valid = '0; a_data = '0; a_sel = '0; a_ordy = 1'b0; a_clr = 1'b0;
    b_valid = '0; b_data = '0; b_sel = '0; b_ordy = 1'b0; b_clr = 1'b0;
    c_valid = '0; c_data = '0; c_sel = '0; c_ordy = 1'b0; c_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset.A.out_valid", 32'(a_ovalid), 32'd0);
    chk("reset.A.in_ready",  32'(a_ready),  32'd0);

    // T2: explicit select of channel 2
    a_sel = 2'd2; a_valid = 4'b0100; a_data = 32'h44A5_2211; a_ordy = 1'b1;
    #1;
    chk("T2.in_ready", 32'(a_ready), 32'h4);
    tick();
    chk("T2.out_data",  32'(a_odata),  32'hA5);
    chk("T2.out_chan",  32'(a_ochan),  32'd2);
    chk("T2.out_valid", 32'(a_ovalid), 32'd1);

    // T3: back-pressure for 3 cycles, then release with no bubble
    a_ordy = 1'b0; a_data = 32'h445A_2211;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("T3.stall_ready", 32'(a_ready), 32'd0);
      chk("T3.stall_data",  32'(a_odata), 32'hA5);
      tick();
    end
    a_ordy = 1'b1;
    #1;
    chk("T3.release_ready", 32'(a_ready), 32'h4);
    tick();
    chk("T3.next_data",  32'(a_odata),  32'h5A);
    chk("T3.next_valid", 32'(a_ovalid), 32'd1);
    chk("T3.cnt",        32'(a_cnt),    32'd2);

    // T1: asynchronous reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    chk("T1.out_valid", 32'(a_ovalid), 32'd0);
    chk("T1.out_data",  32'(a_odata),  32'd0);
    chk("T1.out_chan",  32'(a_ochan),  32'd0);
    chk("T1.xfer_cnt",  32'(a_cnt),    32'd0);
    a_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("T1.ready_after_release", 32'(a_ready), 32'd0);
    tick();

    // T4: round-robin over all channels, then over channels 0 and 3 from rr_ptr=1
    b_valid = 4'b1111; b_data = 32'hD3C2_B1A0; b_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) b_valid = 4'b1001;
      tick();
      chk($sformatf("T4.chan[%0d]", i), 32'(b_ochan), 32'(exp_seq[i]));
    end
    chk("T4.last_data", 32'(b_odata), 32'hD3);
    b_valid = '0;

    // T5: N=3, out-of-range select
    c_sel = 2'd0; c_valid = 3'b001; c_data = 24'h33_2211; c_ordy = 1'b1;
    #1;
    chk("T5.ready0", 32'(c_ready), 32'h1);
    tick();
    chk("T5.chan0", 32'(c_ochan), 32'd0);
    c_sel = 2'd3;
    #1;
    chk("T5.ready_bad_sel", 32'(c_ready), 32'd0);
    tick();
    chk("T5.sel_err",   32'(c_err),    32'd1);
    chk("T5.out_valid", 32'(c_ovalid), 32'd0);
    chk("T5.held_data", 32'(c_odata),  32'h11);
    c_sel = 2'd1; c_valid = 3'b010;
    tick();
    chk("T5.err_pulse_end", 32'(c_err),    32'd0);
    chk("T5.recover_data",  32'(c_odata),  32'h22);
    chk("T5.recover_chan",  32'(c_ochan),  32'd1);
    c_valid = '0;

    // T6: saturating 4-bit counter, then clear with a simultaneous transfer
    a_sel = 2'd0; a_valid = 4'b0001; a_ordy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("T6.saturated", 32'(a_cnt), 32'd15);
    a_clr = 1'b1;
    #1;
    chk("T6.ready_with_clr", 32'(a_ready), 32'h1);
    tick();
    chk("T6.cleared", 32'(a_cnt), 32'd0);
    a_clr = 1'b0;
    tick();
    chk("T6.count_resumes", 32'(a_cnt), 32'd1);
    a_valid = '0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
